// File: rtl/mfcc_pkg.sv
// Shared MFCC front-end definitions: sequencer state encoding, default
// channel count / log width, and the log floor helper.
package mfcc_pkg;

  localparam int unsigned NUM_MEL_DEF = 40;
  localparam int unsigned MEL_AW      = $clog2(NUM_MEL_DEF);
  localparam int unsigned Q_L_DEF     = 11;

  // Fixed encodings kept so existing netlists and dumps stay comparable
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_CAP   = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_EMIT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RD    = ST_RD,
    CAP   = ST_CAP,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    EMIT  = ST_EMIT,
    DONE  = ST_DONE
  } state_t;

  // Most negative value representable in a q_l-bit signed log result
  function automatic int log_floor(input int unsigned q_l);
    return -(32'sd1 <<< (q_l - 1));
  endfunction

endpackage

// File: rtl/mfcc_out_reg.sv
// Single-entry valid/ready holding register for the log-energy stream.
// Contents stay frozen while out_valid is high and out_ready is low.
module mfcc_out_reg #(
  parameter int unsigned DW = 11,
  parameter int unsigned IW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic signed [DW-1:0] load_data,
  input  logic        [IW-1:0] load_index,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic        [IW-1:0] out_index,
  output logic                 out_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_index <= load_index;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mel_log_scheduler.sv
// Frame sequencer feeding Mel energies through the shared log unit to the DCT.
// Define LOG_TIMEOUT_EN to add a per-channel WAIT watchdog (log_timeout).
module mel_log_scheduler
  import mfcc_pkg::*;
#(
  parameter int unsigned NUM_MEL   = NUM_MEL_DEF,
  parameter int unsigned Q_L       = Q_L_DEF,
  parameter int          LOG_FLOOR = log_floor(Q_L),
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  output logic [$clog2(NUM_MEL)-1:0]   mel_rd_addr,
  input  logic signed [31:0]           mel_rd_data,
  output logic signed [31:0]           log_data,
  output logic                         log_data_valid,
  input  logic signed [Q_L-1:0]        log_result,
  input  logic                         log_result_valid,
  output logic signed [Q_L-1:0]        out_data,
  output logic [$clog2(NUM_MEL)-1:0]   out_index,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         frame_overrun,
  output logic                         log_timeout
);

  localparam int unsigned    AW       = $clog2(NUM_MEL);
  localparam logic [AW-1:0]  LAST_IDX = AW'(NUM_MEL - 1);
  localparam logic [31:0]    FLOOR_W  = LOG_FLOOR;
  localparam logic [Q_L-1:0] FLOOR_Q  = FLOOR_W[Q_L-1:0];

  state_t                state;
  logic [AW-1:0]         idx;
  logic signed [31:0]    energy;
  logic                  overrun_q;
  logic                  nonpos;
  logic                  expire;
  logic                  load;
  logic signed [Q_L-1:0] load_data;
  logic                  handshake;

  assign nonpos    = mel_rd_data[31] || (mel_rd_data == '0);
  assign handshake = out_valid && out_ready;

`ifdef LOG_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  // A result arriving on the expiry cycle wins over the watchdog
  assign expire = (state == WAIT) && !log_result_valid &&
                  (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  assign log_timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign log_timeout = 1'b0;
`endif

  // The output register doubles as the result register: it is loaded on
  // entry to EMIT with either the log result or the floor value.
  always_comb begin
    load      = 1'b0;
    load_data = FLOOR_Q;
    if (state == CAP && nonpos) begin
      load = 1'b1;
    end else if (state == WAIT && log_result_valid) begin
      load      = 1'b1;
      load_data = log_result;
    end else if (expire) begin
      load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      energy    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= frame_start && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_start) begin
            idx   <= '0;
            state <= RD;
          end
        end
        RD:    state <= CAP;
        CAP: begin
          energy <= mel_rd_data;
          state  <= nonpos ? EMIT : ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (log_result_valid || expire) begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + AW'(1);
              state <= RD;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mel_rd_addr    = idx;
  assign log_data       = energy;
  assign log_data_valid = (state == ISSUE);
  assign busy           = (state != IDLE);
  assign frame_done     = (state == DONE);
  assign frame_overrun  = overrun_q;

  mfcc_out_reg #(
    .DW (Q_L),
    .IW (AW)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_index (idx),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_valid  (out_valid)
  );

endmodule

// File: tb/tb_mel_log_scheduler.sv
// Directed bench for mel_log_scheduler: RAM model, fixed-latency log model,
// handshake monitor and hand-computed expectations.
module tb_mel_log_scheduler;

  localparam int NUM_MEL = 40;
  localparam int Q_L     = 11;
  localparam int AW      = 6;
  localparam int L       = 5;
  localparam int FLOOR   = -1024;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  frame_start;
  logic [AW-1:0]         mel_rd_addr;
  logic signed [31:0]    mel_rd_data = '0;
  logic signed [31:0]    log_data;
  logic                  log_data_valid;
  logic signed [Q_L-1:0] log_result;
  logic                  log_result_valid;
  logic signed [Q_L-1:0] out_data;
  logic [AW-1:0]         out_index;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  frame_done;
  logic                  frame_overrun;
  logic                  log_timeout;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int st_cyc  = 0;

  logic signed [31:0] mem [NUM_MEL];
  int exp_dat [NUM_MEL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mel_rd_data <= mem[mel_rd_addr];

  // Log unit model: responds L cycles after an issue with energy >> 8
  int                    pend      = 0;
  int                    hang_idx  = -1;
  logic                  mdl_valid = 1'b0;
  logic signed [Q_L-1:0] mdl_res   = '0;
  logic                  inj_valid = 1'b0;

  always @(posedge clk) begin
    mdl_valid <= 1'b0;
    if (rst) begin
      pend <= 0;
    end else if (log_data_valid) begin
      pend <= (int'(mel_rd_addr) == hang_idx) ? 0 : L - 1;
    end else if (pend == 1) begin
      mdl_valid <= 1'b1;
      mdl_res   <= Q_L'(log_data >>> 8);
      pend      <= 0;
    end else if (pend > 1) begin
      pend <= pend - 1;
    end
  end

  assign log_result_valid = mdl_valid | inj_valid;
  assign log_result       = inj_valid ? 11'sh1AB : mdl_res;

  // Monitor
  int hs_idx[$];
  int hs_dat[$];
  int hs_cyc[$];
  int iss_idx[$];
  int done_cnt = 0, done_cyc = 0, ovr_cnt = 0, tmo_cnt = 0, ov_cyc = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      hs_idx.push_back(int'(out_index));
      hs_dat.push_back(int'(out_data));
      hs_cyc.push_back(cyc);
    end
    if (log_data_valid) iss_idx.push_back(int'(mel_rd_addr));
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (frame_overrun) ovr_cnt = ovr_cnt + 1;
    if (log_timeout) tmo_cnt = tmo_cnt + 1;
    if (out_valid) ov_cyc = ov_cyc + 1;
  end

  mel_log_scheduler #(
    .NUM_MEL (NUM_MEL),
    .Q_L     (Q_L),
    .TIMEOUT (64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .mel_rd_addr      (mel_rd_addr),
    .mel_rd_data      (mel_rd_data),
    .log_data         (log_data),
    .log_data_valid   (log_data_valid),
    .log_result       (log_result),
    .log_result_valid (log_result_valid),
    .out_data         (out_data),
    .out_index        (out_index),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_overrun    (frame_overrun),
    .log_timeout      (log_timeout)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt = vec_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_idx.delete();
    hs_dat.delete();
    hs_cyc.delete();
    iss_idx.delete();
    done_cnt = 0;
    ovr_cnt  = 0;
    tmo_cnt  = 0;
    ov_cyc   = 0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    st_cyc      = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (3) tick();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NUM_MEL; i++) begin
      mem[i]     = 32'h0001_0000 + i * 256;
      exp_dat[i] = 256 + i;
    end
  endtask

  task automatic check_frame(input string pfx);
    chk({pfx, "_hs_count"}, hs_idx.size(), NUM_MEL);
    if (hs_idx.size() == NUM_MEL) begin
      for (int i = 0; i < NUM_MEL; i++) begin
        chk($sformatf("%s_index%0d", pfx, i), hs_idx[i], i);
        chk($sformatf("%s_data%0d", pfx, i), hs_dat[i], exp_dat[i]);
      end
      chk({pfx, "_done_lat"}, done_cyc - hs_cyc[NUM_MEL-1], 1);
    end
    chk({pfx, "_done_once"}, done_cnt, 1);
    chk({pfx, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_mel_rd_addr"}, int'(mel_rd_addr), 0);
    chk({pfx, "_log_data"}, int'(log_data), 0);
    chk({pfx, "_log_data_valid"}, int'(log_data_valid), 0);
    chk({pfx, "_out_data"}, int'(out_data), 0);
    chk({pfx, "_out_index"}, int'(out_index), 0);
    chk({pfx, "_out_valid"}, int'(out_valid), 0);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_frame_done"}, int'(frame_done), 0);
    chk({pfx, "_frame_overrun"}, int'(frame_overrun), 0);
    chk({pfx, "_log_timeout"}, int'(log_timeout), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int bad;
    int sd;
    int si;
    rst         = 1'b1;
    frame_start = 1'b0;
    out_ready   = 1'b1;
    for (int i = 0; i < NUM_MEL; i++) begin
      mem[i]     = 32'h0001_0000;
      exp_dat[i] = 256;
    end
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Uniform energies, L=5: 9 cycles per channel
    clear_mon();
    start_frame();
    wait_done(1000);
    check_frame("uni");
    chk("uni_issues", iss_idx.size(), NUM_MEL);
    if (hs_cyc.size() == NUM_MEL) begin
      chk("uni_ch0_lat", hs_cyc[0] - st_cyc, 9);
      for (int i = 1; i < NUM_MEL; i++)
        chk($sformatf("uni_gap%0d", i), hs_cyc[i] - hs_cyc[i-1], 9);
    end

    // Zero and negative energies bypass the log unit
    fill_ramp();
    mem[3]     = 32'h0000_0000;
    mem[7]     = 32'h8000_0000;
    exp_dat[3] = FLOOR;
    exp_dat[7] = FLOOR;
    clear_mon();
    start_frame();
    wait_done(1000);
    check_frame("byp");
    chk("byp_issues", iss_idx.size(), NUM_MEL - 2);
    bad = 0;
    foreach (iss_idx[k]) if (iss_idx[k] == 3 || iss_idx[k] == 7) bad++;
    chk("byp_no_issue_3_7", bad, 0);
    if (hs_cyc.size() == NUM_MEL) begin
      chk("byp_gap3", hs_cyc[3] - hs_cyc[2], 3);
      chk("byp_gap4", hs_cyc[4] - hs_cyc[3], 9);
      chk("byp_gap7", hs_cyc[7] - hs_cyc[6], 3);
    end

    // Back-pressure for 10 cycles at channel 12
    fill_ramp();
    clear_mon();
    start_frame();
    n = 0;
    while (mel_rd_addr != 6'd12 && n < 500) begin tick(); n++; end
    out_ready = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
    sd = int'(out_data);
    si = int'(out_index);
    chk("stall_index", si, 12);
    chk("stall_data", sd, 268);
    bad = 0;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b1 || int'(out_data) != sd || int'(out_index) != si) bad++;
    end
    chk("stall_frozen", bad, 0);
    out_ready = 1'b1;
    tick();
    chk("stall_next_rd_addr", int'(mel_rd_addr), 13);
    chk("stall_next_valid", int'(out_valid), 0);
    tick();
    tick();
    chk("stall_next_issue", int'(log_data_valid), 1);
    wait_done(1000);
    check_frame("stall");
    if (hs_cyc.size() == NUM_MEL) chk("stall_gap12", hs_cyc[12] - hs_cyc[11], 19);

    // frame_start during WAIT and during DONE are both overruns
    fill_ramp();
    clear_mon();
    start_frame();
    n = 0;
    while (!(log_data_valid && mel_rd_addr == 6'd20) && n < 500) begin tick(); n++; end
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_busy", int'(busy), 1);
    n = 0;
    while (frame_done !== 1'b1 && n < 500) begin tick(); n++; end
    chk("ovr_done_reached", int'(frame_done), 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    check_frame("ovr");
    chk("ovr_pulses", ovr_cnt, 2);
    if (hs_idx.size() > 0) chk("ovr_last_index", hs_idx[hs_idx.size()-1], NUM_MEL - 1);

    // Reset in WAIT, late result must be ignored
    fill_ramp();
    clear_mon();
    start_frame();
    n = 0;
    while (!(log_data_valid && mel_rd_addr == 6'd2) && n < 500) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    inj_valid = 1'b1;
    check_reset_outputs("mid_rst");
    tick();
    inj_valid = 1'b0;
    ov_cyc    = 0;
    repeat (20) tick();
    chk("mid_rst_no_out_valid", ov_cyc, 0);
    chk("mid_rst_idle", int'(busy), 0);
    chk("mid_rst_out_data", int'(out_data), 0);

`ifdef LOG_TIMEOUT_EN
    // Log unit silent at channel 5: watchdog substitutes the floor
    fill_ramp();
    exp_dat[5] = FLOOR;
    hang_idx   = 5;
    clear_mon();
    start_frame();
    wait_done(2000);
    hang_idx = -1;
    check_frame("tmo");
    chk("tmo_pulses", tmo_cnt, 1);
    if (hs_cyc.size() == NUM_MEL) chk("tmo_gap5", hs_cyc[5] - hs_cyc[4], 68);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
